// File: rtl/sr_bank_scheduler_pkg.sv
// Shared opcodes, FSM state type and opcode-to-SR decode for sr_bank_scheduler.
package sr_sched_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_BOTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    APPLY = 2'b01,
    ACK   = 2'b10
  } state_e;

  typedef struct packed {
    logic s;
    logic r;
  } sr_t;

  // OP_BOTH raises both s and r; the cell resolves that to 0.
  function automatic sr_t decode_op(input logic [1:0] op);
    sr_t d;
    d.s = (op == OP_SET) || (op == OP_BOTH);
    d.r = (op == OP_CLR) || (op == OP_BOTH);
    return d;
  endfunction

endpackage

// File: rtl/sr_bank_scheduler_if.sv
// Requester-side bus of sr_bank_scheduler: packed per-requester commands plus
// grant/ack/err/busy status and the flag bank contents.
interface sr_bank_scheduler_if #(
  parameter int N     = 4,
  parameter int M     = 8,
  parameter int IDX_W = $clog2(M)
);

  logic [N-1:0]       req;
  logic [2*N-1:0]     op;
  logic [N*IDX_W-1:0] idx;
  logic [N-1:0]       grant;
  logic [N-1:0]       ack;
  logic               err;
  logic               busy;
  logic [M-1:0]       flags;

  modport master (
    output req, op, idx,
    input  grant, ack, err, busy, flags
  );

  modport slave (
    input  req, op, idx,
    output grant, ack, err, busy, flags
  );

endinterface

// File: rtl/sr_bank_scheduler_cell.sv
// One SR flag cell: s&&r -> 0, s -> 1, r -> 0, else hold.
// With SR_BANK_AUTOCLR_EN defined, a SET also arms a HOLD_CYCLES auto-clear timer.
module sr_cell #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q
);

`ifdef SR_BANK_AUTOCLR_EN
  localparam int               CNT_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic             q_q;
  logic             auto_r;

  // Internal clear fires on the edge where the timer steps from 1 to 0.
  assign auto_r = q_q && (cnt_q == CNT_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q   <= 1'b0;
      cnt_q <= '0;
    end else if (s && r) begin
      q_q   <= 1'b0;
      cnt_q <= '0;
    end else if (s) begin
      q_q   <= 1'b1;
      cnt_q <= HOLD_LOAD;
    end else if (r || auto_r) begin
      q_q   <= 1'b0;
      cnt_q <= '0;
    end else if (q_q && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  assign q = q_q;
`else
  // NOTE: sequential state uses non-blocking assignments so every cell and
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       q <= 1'b0;
    else if (s && r) q <= 1'b0;
    else if (s)      q <= 1'b1;
    else if (r)      q <= 1'b0;
  end
`endif

endmodule

// File: rtl/sr_bank_scheduler.sv
// Round-robin scheduler serialising N requesters' set/clear commands onto an
// M-cell SR flag bank. Optional auto-clear cells: define SR_BANK_AUTOCLR_EN.
module sr_bank_scheduler
  import sr_sched_pkg::*;
#(
  parameter int N           = 4,
  parameter int M           = 8,
  parameter int IDX_W       = $clog2(M),
  parameter int HOLD_CYCLES = 16
) (
  input logic              clk,
  input logic              reset,
  sr_bank_scheduler_if.slave bus
);

  localparam int               PTR_W = $clog2(N);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(N - 1);
  localparam logic [PTR_W-1:0] ONE   = PTR_W'(1);

  state_e           state_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [1:0]       op_q;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     grant_q;
  logic [N-1:0]     ack_q;
  logic             err_q;
  logic             busy_q;

  logic [PTR_W-1:0] winner_d;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [N-1:0]     grant_d;
  logic [1:0]       op_d;
  logic [IDX_W-1:0] idx_d;
  logic             found;
  int               cand;

  logic             idx_oob;
  sr_t              sr_cmd;
  logic [M-1:0]     s_vec;
  logic [M-1:0]     r_vec;
  logic [M-1:0]     flags_w;

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    winner_d = rr_ptr_q;
    found    = 1'b0;
    cand     = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(rr_ptr_q) + k) % N;
      if (!found && bus.req[cand]) begin
        found    = 1'b1;
        winner_d = PTR_W'(cand);
      end
    end
    rr_ptr_d          = (winner_d == LAST) ? '0 : winner_d + ONE;
    grant_d           = '0;
    grant_d[winner_d] = 1'b1;
    op_d              = bus.op[2*int'(winner_d) +: 2];
    idx_d             = bus.idx[IDX_W*int'(winner_d) +: IDX_W];
  end

  assign idx_oob = (int'(idx_q) >= M);

  // Only the latched cell sees s/r, and only during APPLY.
  always_comb begin
    sr_cmd = decode_op(op_q);
    s_vec  = '0;
    r_vec  = '0;
    if (state_q == APPLY && !idx_oob) begin
      s_vec[idx_q] = sr_cmd.s;
      r_vec[idx_q] = sr_cmd.r;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      op_q     <= OP_NOP;
      idx_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|bus.req) begin
            op_q     <= op_d;
            idx_q    <= idx_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
            state_q  <= APPLY;
          end
        end
        APPLY: begin
          ack_q   <= grant_q;
          err_q   <= idx_oob;
          state_q <= ACK;
        end
        ACK: begin
          grant_q <= '0;
          ack_q   <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= '0;
          ack_q   <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_cell
    sr_cell #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .s    (s_vec[i]),
      .r    (r_vec[i]),
      .q    (flags_w[i])
    );
  end

  assign bus.grant = grant_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
  assign bus.flags = flags_w;

endmodule

// File: tb/tb_sr_bank_scheduler.sv
// Self-checking bench for sr_bank_scheduler: table vectors, hand sequences and
// randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_sr_bank_scheduler;
  import sr_sched_pkg::*;

  localparam int N     = 4;
  localparam int M     = 8;
  localparam int IDX_W = 3;
  localparam int HOLD  = 16;
  localparam int M_B   = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_bank_scheduler_if #(.N(N), .M(M))   bus_a ();
  sr_bank_scheduler_if #(.N(N), .M(M_B)) bus_b ();

  sr_bank_scheduler #(.N(N), .M(M), .HOLD_CYCLES(HOLD)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  sr_bank_scheduler #(.N(N), .M(M_B), .HOLD_CYCLES(HOLD)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: flag values, last SET cycle per flag, round-robin pointer.
  logic [M-1:0] m_flag;
  int           m_set_cyc [M];
  int           m_ptr;

  // Requester-side command state driven onto bus_a.
  logic [N-1:0] pend;
  logic [1:0]   c_op  [N];
  logic [2:0]   c_idx [N];

  function automatic logic [M-1:0] exp_flags();
    logic [M-1:0] v;
    v = m_flag;
`ifdef SR_BANK_AUTOCLR_EN
    for (int b = 0; b < M; b++)
      if (cyc - m_set_cyc[b] >= HOLD) v[b] = 1'b0;
`endif
    return v;
  endfunction

  function automatic int pick(input logic [N-1:0] p);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (p[c]) return c;
    end
    return 0;
  endfunction

  task automatic apply_model(input logic [1:0] op, input int idx);
    if (idx < M) begin
      case (op)
        OP_SET:          begin m_flag[idx] = 1'b1; m_set_cyc[idx] = cyc; end
        OP_CLR, OP_BOTH: m_flag[idx] = 1'b0;
        default:         ;
      endcase
    end
  endtask

  task automatic model_reset();
    m_flag = '0;
    m_ptr  = 0;
    for (int b = 0; b < M; b++) m_set_cyc[b] = -1000;
  endtask

  task automatic drive_a();
    bus_a.req = pend;
    for (int i = 0; i < N; i++) begin
      bus_a.op[2*i +: 2]          = c_op[i];
      bus_a.idx[IDX_W*i +: IDX_W] = c_idx[i];
    end
  endtask

  task automatic new_cmd(input int i);
    pend[i]  = 1'b1;
    c_op[i]  = 2'($urandom_range(0, 3));
    c_idx[i] = 3'($urandom_range(0, M - 1));
  endtask

  // mode: 0 = winner drops req at ack, 1 = random traffic, 2 = winner keeps req.
  task automatic run_txn(input string tag, input int mode, input bit use_tbl,
                         input logic [M-1:0] tbl_flags, output logic [N-1:0] g_seen);
    int           w;
    logic [N-1:0] eg;
    w      = pick(pend);
    eg     = '0;
    eg[w]  = 1'b1;
    tick();  // E0
    g_seen = bus_a.grant;
    check({tag, " grant@E0"}, bus_a.grant, eg);
    check({tag, " busy@E0"},  bus_a.busy,  1'b1);
    check({tag, " ack@E0"},   bus_a.ack,   '0);
    m_ptr = (w + 1) % N;
    if (mode == 1)
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) new_cmd(i);
    drive_a();
    tick();  // E1
    apply_model(c_op[w], int'(c_idx[w]));
    check({tag, " ack@E1"},   bus_a.ack,   eg);
    check({tag, " grant@E1"}, bus_a.grant, eg);
    check({tag, " err@E1"},   bus_a.err,   1'b0);
    check({tag, " flags@E1"}, bus_a.flags, exp_flags());
`ifndef SR_BANK_AUTOCLR_EN
    if (use_tbl) check({tag, " tbl_flags"}, bus_a.flags, tbl_flags);
`endif
    if (mode == 2)                                  ;
    else if (mode == 1 && $urandom_range(0, 1) == 1) new_cmd(w);
    else                                            pend[w] = 1'b0;
    drive_a();
    tick();  // E2
    check({tag, " grant@E2"}, bus_a.grant, '0);
    check({tag, " ack@E2"},   bus_a.ack,   '0);
    check({tag, " err@E2"},   bus_a.err,   1'b0);
    check({tag, " busy@E2"},  bus_a.busy,  1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend  = '0;
    drive_a();
    tick();
    tick();
    model_reset();
    check("rst grant", bus_a.grant, '0);
    check("rst ack",   bus_a.ack,   '0);
    check("rst err",   bus_a.err,   1'b0);
    check("rst busy",  bus_a.busy,  1'b0);
    check("rst flags", bus_a.flags, '0);
    check("rst b err", bus_b.err,   1'b0);
    reset = 1'b0;
  endtask

  task automatic txn_b(input int idx, input bit exp_err, input logic [M_B-1:0] exp_fl);
    bus_b.req       = 4'b0010;
    bus_b.op[3:2]   = OP_SET;
    bus_b.idx[5:3]  = 3'(idx);
    tick();
    check("b grant@E0", bus_b.grant, 4'b0010);
    tick();
    check("b ack@E1",   bus_b.ack,   4'b0010);
    check("b err@E1",   bus_b.err,   exp_err);
    check("b flags@E1", bus_b.flags, exp_fl);
    bus_b.req = '0;
    tick();
    check("b err@E2",   bus_b.err,   1'b0);
    check("b ack@E2",   bus_b.ack,   '0);
  endtask

  typedef struct {
    int           rq;
    logic [1:0]   op;
    int           idx;
    logic [M-1:0] flags;
  } vec_t;

  initial begin
    vec_t         tbl [8];
    logic [N-1:0] g;

    tbl[0] = '{2, OP_SET,  5, 8'h20};
    tbl[1] = '{0, OP_SET,  0, 8'h21};
    tbl[2] = '{3, OP_SET,  3, 8'h29};
    tbl[3] = '{1, OP_BOTH, 3, 8'h21};
    tbl[4] = '{1, OP_NOP,  0, 8'h21};
    tbl[5] = '{2, OP_CLR,  5, 8'h01};
    tbl[6] = '{0, OP_SET,  7, 8'h81};
    tbl[7] = '{3, OP_CLR,  0, 8'h80};

    for (int i = 0; i < N; i++) begin c_op[i] = OP_NOP; c_idx[i] = '0; end
    pend      = '0;
    bus_b.req = '0;
    bus_b.op  = '0;
    bus_b.idx = '0;
    drive_a();
    model_reset();
    do_reset();

    // Single-requester vectors
    for (int t = 0; t < 8; t++) begin
      pend              = '0;
      pend[tbl[t].rq]   = 1'b1;
      c_op[tbl[t].rq]   = tbl[t].op;
      c_idx[tbl[t].rq]  = 3'(tbl[t].idx);
      drive_a();
      run_txn($sformatf("tbl%0d", t), 0, 1'b1, tbl[t].flags, g);
    end

    // All four requesting continuously: grants 0,1,2,3,0 back-to-back
    do_reset();
    pend = 4'b1111;
    for (int i = 0; i < N; i++) begin c_op[i] = OP_SET; c_idx[i] = 3'(i); end
    drive_a();
    for (int k = 0; k < 5; k++) begin
      run_txn($sformatf("rr%0d", k), (k == 4) ? 0 : 2, 1'b0, '0, g);
      check($sformatf("rr order %0d", k), g, 4'b0001 << (k % 4));
      if (k == 3) check("rr flags after 4", bus_a.flags, 8'h0F);
    end
    pend = '0;
    drive_a();

    // Reset while in APPLY drops the command and rewinds the pointer
    pend     = 4'b0010;
    c_op[1]  = OP_SET;
    c_idx[1] = 3'd6;
    drive_a();
    tick();
    check("mid grant", bus_a.grant, 4'b0010);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("mid flags", bus_a.flags, '0);
    check("mid busy",  bus_a.busy,  1'b0);
    check("mid grant0", bus_a.grant, '0);
    pend = '0;
    drive_a();
    tick();
    check("mid no ack", bus_a.ack, '0);
    reset = 1'b0;
    pend     = 4'b1001;
    c_op[0]  = OP_SET; c_idx[0] = 3'd2;
    c_op[3]  = OP_SET; c_idx[3] = 3'd4;
    drive_a();
    run_txn("post", 0, 1'b0, '0, g);
    check("post ptr0 grant", g, 4'b0001);
    run_txn("post2", 0, 1'b0, '0, g);
    check("post2 grant", g, 4'b1000);

    // Out-of-range index on the M=6 instance
    txn_b(7, 1'b1, 6'h00);
    txn_b(6, 1'b1, 6'h00);
    txn_b(5, 1'b0, 6'h20);

    // Randomized traffic against the model
    for (int t = 0; t < 60; t++) begin
      if (pend == '0) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          check("rnd idle busy", bus_a.busy, 1'b0);
        end
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 1) == 1) new_cmd(i);
        if (pend == '0) new_cmd(int'($urandom_range(0, N - 1)));
        drive_a();
      end
      run_txn("rnd", 1, 1'b0, '0, g);
    end
    pend = '0;
    drive_a();

`ifdef SR_BANK_AUTOCLR_EN
    begin
      int b;
      do_reset();
      pend = 4'b0001; c_op[0] = OP_SET; c_idx[0] = 3'd0;
      drive_a();
      tick();
      tick();
      b = cyc;
      pend = '0;
      drive_a();
      check("ac set", bus_a.flags[0], 1'b1);
      for (int k = 1; k <= 16; k++) begin
        tick();
        check($sformatf("ac hold %0d", k), bus_a.flags[0], k < 16);
      end
      pend = 4'b0001;
      drive_a();
      tick();
      tick();
      b = cyc;
      pend = '0;
      drive_a();
      while (cyc - b < 8) tick();
      pend = 4'b0001;
      drive_a();
      tick();
      tick();
      pend = '0;
      drive_a();
      check("ac reset at 10", cyc - b, 10);
      while (cyc - b < 26) begin
        tick();
        check($sformatf("ac ext %0d", cyc - b), bus_a.flags[0], (cyc - b) < 26);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
